mcycle_ctrl: RTL and testbench

MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

---
 rtl/mcycle_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mcycle_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcycle_ctrl.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback.
// Latency: R/I/sw/jal 4 cycles, lw 5, beq 3; each mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE adds one.
// Backpressure: mem_ready=0 holds FETCH, MEMREAD and MEMWRITE (ignored when MEM_WAIT_EN=0).
// Ports: clk/reset (sync, active-high); op/funct3/zero/mem_ready in; datapath
// enables (IRwrite, PCwrite, AdrSrc, MemWrite, RegWrite), mux selects (ALUSrcA,
// ALUSrcB, ResultSrc, ALUOp, ImmSrc), illegal_op flag and debug state code out.
module mcycle_ctrl #(
    parameter int unsigned MEM_WAIT_EN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       IRwrite,
    output logic       PCwrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    state_t state_q, state_d, cur_st;
    logic   mem_rdy;

    assign mem_rdy = (MEM_WAIT_EN == 0) ? 1'b1 : mem_ready;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        // While reset is held the outputs look like FETCH, whatever state_q holds.
        cur_st     = reset ? S_FETCH : state_q;
        state_d    = S_FETCH;
        IRwrite    = 1'b0;
        PCwrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUOp      = 2'b00;
        illegal_op = 1'b0;
        case (cur_st)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRwrite   = mem_rdy;
                PCwrite   = mem_rdy;
                state_d   = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // oldPC + imm: branch target ready for BEQ.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BR:             state_d = S_BEQ;
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                state_d  = mem_rdy ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
            end
            S_JAL: begin
                // PC <= branch target from DECODE, ALU computes oldPC+4 for rd.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCwrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                case (funct3)
                    3'b000:  PCwrite = zero;
                    3'b001:  PCwrite = ~zero;
                    default: PCwrite = 1'b0;
                endcase
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE: ImmSrc = 2'b01;
            OP_BR:    ImmSrc = 2'b10;
            OP_JAL:   ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

    assign state = cur_st;

endmodule

// File: tb/tb_mcycle_ctrl.sv
module tb_mcycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       IRwrite, PCwrite, AdrSrc, MemWrite, RegWrite, illegal_op;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp, ImmSrc;
    logic [3:0] state;

    mcycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .IRwrite(IRwrite), .PCwrite(PCwrite),
        .AdrSrc(AdrSrc), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ALUOp(ALUOp), .ImmSrc(ImmSrc), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] SYS = 7'b1110011;

    typedef struct packed {
        logic [3:0] st;
        logic       irw, pcw, adr, mw, rw, ill;
        logic [1:0] a, b, rs, aluop, imm;
    } rec_t;

    rec_t obs_q[$];
    rec_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference: what the controller must show in a given state, from the state tables.
    function automatic rec_t exp_rec(int st, bit mr, logic [6:0] o, logic [2:0] f3, bit z);
        rec_t r;
        r     = '0;
        r.st  = st[3:0];
        r.imm = (o == SW) ? 2'b01 : (o == BR) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
        case (st)
            0:  begin r.b = 2'b10; r.rs = 2'b10; r.irw = mr; r.pcw = mr; end
            1:  begin r.a = 2'b01; r.b = 2'b01; r.ill = !(o inside {LW, SW, RT, IT, JL, BR}); end
            2:  begin r.a = 2'b10; r.b = 2'b01; end
            3:  r.adr = 1'b1;
            4:  begin r.rs = 2'b01; r.rw = 1'b1; end
            5:  begin r.adr = 1'b1; r.mw = 1'b1; end
            6:  begin r.a = 2'b10; r.aluop = 2'b10; end
            7:  r.rw = 1'b1;
            8:  begin r.a = 2'b10; r.b = 2'b01; r.aluop = 2'b10; end
            9:  begin r.a = 2'b01; r.b = 2'b10; r.pcw = 1'b1; end
            10: begin r.a = 2'b10; r.aluop = 2'b01; r.pcw = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : 1'b0; end
            default: ;
        endcase
        return r;
    endfunction

    // Expected per-cycle trace of one instruction, FETCH through the last state.
    task automatic build_exp(input logic [6:0] o, input logic [2:0] f3, input bit z,
                             input int fw, input int mw);
        exp_q = {};
        for (int i = 0; i < fw; i++) exp_q.push_back(exp_rec(0, 0, o, f3, z));
        exp_q.push_back(exp_rec(0, 1, o, f3, z));
        exp_q.push_back(exp_rec(1, 0, o, f3, z));
        case (o)
            LW: begin
                exp_q.push_back(exp_rec(2, 0, o, f3, z));
                for (int i = 0; i <= mw; i++) exp_q.push_back(exp_rec(3, 0, o, f3, z));
                exp_q.push_back(exp_rec(4, 0, o, f3, z));
            end
            SW: begin
                exp_q.push_back(exp_rec(2, 0, o, f3, z));
                for (int i = 0; i <= mw; i++) exp_q.push_back(exp_rec(5, 0, o, f3, z));
            end
            RT: begin exp_q.push_back(exp_rec(6, 0, o, f3, z)); exp_q.push_back(exp_rec(7, 0, o, f3, z)); end
            IT: begin exp_q.push_back(exp_rec(8, 0, o, f3, z)); exp_q.push_back(exp_rec(7, 0, o, f3, z)); end
            JL: begin exp_q.push_back(exp_rec(9, 0, o, f3, z)); exp_q.push_back(exp_rec(7, 0, o, f3, z)); end
            BR: exp_q.push_back(exp_rec(10, 0, o, f3, z));
            default: ;
        endcase
    endtask

    function automatic rec_t cap();
        rec_t r;
        r.st = state; r.irw = IRwrite; r.pcw = PCwrite; r.adr = AdrSrc;
        r.mw = MemWrite; r.rw = RegWrite; r.ill = illegal_op;
        r.a = ALUSrcA; r.b = ALUSrcB; r.rs = ResultSrc; r.aluop = ALUOp; r.imm = ImmSrc;
        return r;
    endfunction

    // Runs one instruction starting in FETCH just after a falling edge. mem_ready is
    // low for fw FETCH cycles and mw memory-state cycles, random elsewhere.
    task automatic exec_instr(input logic [6:0] o, input logic [2:0] f3, input bit z,
                              input int fw, input int mw);
        int fcnt = 0;
        int mcnt = 0;
        bit left = 0;
        obs_q = {};
        op = o; funct3 = f3; zero = z;
        for (int c = 0; c < 40; c++) begin
            if (left && state == 4'd0) break;
            if (state == 4'd0) begin
                mem_ready = (fcnt >= fw); fcnt++;
            end else if (state == 4'd3 || state == 4'd5) begin
                mem_ready = (mcnt >= mw); mcnt++;
                left = 1;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
                left = 1;
            end
            #1;
            obs_q.push_back(cap());
            @(negedge clk);
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rec_t e, o;
        op = RT; funct3 = 3'd0; zero = 1'b0; mem_ready = 1'b0; reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        o = cap(); e = exp_rec(0, 0, RT, 3'd0, 1'b0);
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL reset_outputs_mr0 got %h exp %h", o, e); end
        mem_ready = 1'b1;
        #1;
        o = cap(); e = exp_rec(0, 1, RT, 3'd0, 1'b0);
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL reset_outputs_mr1 got %h exp %h", o, e); end
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            o = cap(); e = exp_rec(0, 0, RT, 3'd0, 1'b0);
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL fetch_wait_after_reset[%0d] got %h exp %h", i, o, e); end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [6:0] o;
        logic [2:0] f3;
        bit         z;
        int         fw;
        int         mw;
    } vec_t;

    task automatic test_directed();
        vec_t v[12];
        int   mw_cnt;
        v[0]  = '{RT, 3'd0, 1'b0, 0, 0};   // add
        v[1]  = '{LW, 3'd2, 1'b0, 0, 2};   // lw, two memory waits
        v[2]  = '{SW, 3'd2, 1'b1, 0, 1};   // sw, one memory wait
        v[3]  = '{BR, 3'd0, 1'b1, 0, 0};   // beq taken
        v[4]  = '{BR, 3'd0, 1'b0, 0, 0};   // beq not taken
        v[5]  = '{BR, 3'd1, 1'b1, 0, 0};   // bne not taken
        v[6]  = '{BR, 3'd1, 1'b0, 0, 0};   // bne taken
        v[7]  = '{BR, 3'd4, 1'b1, 0, 0};   // other funct3 never branches
        v[8]  = '{JL, 3'd0, 1'b0, 0, 0};
        v[9]  = '{IT, 3'd0, 1'b0, 1, 0};
        v[10] = '{SYS, 3'd0, 1'b0, 0, 0};  // unsupported opcode
        v[11] = '{LW, 3'd2, 1'b0, 2, 0};   // fetch waits
        for (int k = 0; k < 12; k++) begin
            build_exp(v[k].o, v[k].f3, v[k].z, v[k].fw, v[k].mw);
            exec_instr(v[k].o, v[k].f3, v[k].z, v[k].fw, v[k].mw);
            n_tests++;
            if (obs_q.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL dir%0d_cycles got %0d exp %0d", k, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_tests++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL dir%0d_cyc%0d got %h exp %h", k, i, obs_q[i], exp_q[i]);
                end
            end
            if (k == 2) begin
                mw_cnt = 0;
                foreach (obs_q[i]) if (obs_q[i].mw === 1'b1) mw_cnt++;
                n_tests++;
                if (mw_cnt != 2) begin n_fail++; $display("FAIL sw_memwrite_cycles got %0d exp 2", mw_cnt); end
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] ops[8];
        logic [6:0] o;
        logic [2:0] f3;
        bit         z;
        int         fw, mw;
        ops = '{LW, SW, RT, IT, JL, BR, SYS, 7'h00};
        for (int k = 0; k < 80; k++) begin
            o  = ops[$urandom_range(0, 7)];
            if (o == 7'h00) o = 7'($urandom);
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 1));
            z  = 1'($urandom_range(0, 1));
            fw = $urandom_range(0, 3);
            mw = $urandom_range(0, 3);
            build_exp(o, f3, z, fw, mw);
            exec_instr(o, f3, z, fw, mw);
            n_tests++;
            if (obs_q.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL rnd%0d_cycles op=%b got %0d exp %0d", k, o, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_tests++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rnd%0d_cyc%0d op=%b got %h exp %h", k, i, o, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        rec_t e, o;
        // Reset in MEMREAD while memory stalls.
        op = LW; funct3 = 3'd2; zero = 1'b0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        o = cap(); e = exp_rec(3, 0, LW, 3'd2, 1'b0);
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL reach_memread got %h exp %h", o, e); end
        reset = 1'b1;
        #1;
        o = cap(); e = exp_rec(0, 0, LW, 3'd2, 1'b0);
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL reset_in_memread_outputs got %h exp %h", o, e); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        o = cap();
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL after_reset_memread got %h exp %h", o, e); end
        // Reset in MEMWRITE while memory stalls.
        op = SW; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        o = cap(); e = exp_rec(5, 0, SW, 3'd2, 1'b0);
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL reach_memwrite got %h exp %h", o, e); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        o = cap(); e = exp_rec(0, 0, SW, 3'd2, 1'b0);
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL after_reset_memwrite got %h exp %h", o, e); end
        @(negedge clk);
        #1;
        o = cap();
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL fetch_hold_mr0 got %h exp %h", o, e); end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; op = 7'd0; funct3 = 3'd0; zero = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

endmodule
